// File: rtl/ysyx_24080006_pkg.sv
// ysyx_24080006 shared definitions used by the load/store unit.
//   lsu_mem_op_e : memory-operation class carried from EXU
//   lsu_exc_e    : exception code reported to WBU
//   F3_*         : RV32 load/store funct3 encodings
package ysyx_24080006_pkg;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_LOAD  = 2'b01,
    MEM_STORE = 2'b10,
    MEM_RSVD  = 2'b11
  } lsu_mem_op_e;

  typedef enum logic [1:0] {
    EXC_NONE        = 2'b00,
    EXC_LD_MISALIGN = 2'b01,
    EXC_ST_MISALIGN = 2'b10,
    EXC_ILLEGAL     = 2'b11
  } lsu_exc_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/ysyx_24080006_lsu_align.sv
// Combinational load-data aligner and access checker.
//   rdata/load_addr_lo/load_funct3 -> load_data : lane extract + sign/zero extend
//   chk_mem_op/chk_funct3/chk_addr_lo -> illegal, misalign : decode-time checks
// The two port groups are independent: extraction works on the latched
// request, the checks work on the instruction being offered by EXU.
module ysyx_24080006_lsu_align
  import ysyx_24080006_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  load_addr_lo,
  input  logic [2:0]  load_funct3,
  output logic [31:0] load_data,
  input  logic [1:0]  chk_mem_op,
  input  logic [2:0]  chk_funct3,
  input  logic [1:0]  chk_addr_lo,
  output logic        illegal,
  output logic        misalign
);

  logic [31:0] shifted;
  logic        is_load;
  logic        is_store;
  logic        f3_legal;

  // The bus word carries the addressed byte in its natural AXI lane.
  assign shifted = rdata >> {load_addr_lo, 3'b000};

  always_comb begin
    case (load_funct3)
      F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   load_data = {24'd0, shifted[7:0]};
      F3_HU:   load_data = {16'd0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  assign is_load  = (lsu_mem_op_e'(chk_mem_op) == MEM_LOAD);
  assign is_store = (lsu_mem_op_e'(chk_mem_op) == MEM_STORE);

  always_comb begin
    f3_legal = 1'b0;
    if (is_load)
      f3_legal = (chk_funct3 == F3_B) || (chk_funct3 == F3_H) || (chk_funct3 == F3_W) ||
                 (chk_funct3 == F3_BU) || (chk_funct3 == F3_HU);
    else if (is_store)
      f3_legal = (chk_funct3 == F3_B) || (chk_funct3 == F3_H) || (chk_funct3 == F3_W);
  end

  // Reserved mem_op is illegal regardless of funct3; NONE is never illegal.
  assign illegal = (lsu_mem_op_e'(chk_mem_op) == MEM_RSVD) || ((is_load || is_store) && !f3_legal);

  // Alignment only matters for a legal access; funct3[1:0] is the size.
  assign misalign = (is_load || is_store) && f3_legal &&
                    (((chk_funct3[1:0] == 2'b01) && chk_addr_lo[0]) ||
                     ((chk_funct3[1:0] == 2'b10) && (chk_addr_lo != 2'b00)));

endmodule

// File: rtl/ysyx_24080006_lsu.sv
// ysyx_24080006 load/store unit: EXU -> (DCU) -> WBU.
//   clock, reset           : core clock, asynchronous active-high reset
//   exu2lsu_valid/ready    : instruction handshake from EXU (exu_* fields)
//   lsu2dcu_valid/ready    : request handshake to DCU (dcu_* fields, registered)
//   lsu2dcu_ready/dcu2lsu_valid : response pulse from DCU with dcu_rdata
//   lsu2wbu_valid/ready    : result handshake to WBU (lsu_result/exc/badaddr)
module ysyx_24080006_lsu
  import ysyx_24080006_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        exu2lsu_valid,
  output logic        lsu2exu_ready,
  input  logic [1:0]  exu_mem_op,
  input  logic [2:0]  exu_funct3,
  input  logic [31:0] exu_addr,
  input  logic [31:0] exu_wdata,
  input  logic [31:0] exu_result,
  output logic        lsu2wbu_valid,
  input  logic        wbu2lsu_ready,
  output logic [31:0] lsu_result,
  output logic [1:0]  lsu_exc,
  output logic [31:0] lsu_badaddr,
  output logic [31:0] dcu_addr,
  output logic [1:0]  dcu_size,
  output logic        dcu_write,
  output logic [31:0] dcu_wdata,
  input  logic [31:0] dcu_rdata,
  output logic        lsu2dcu_valid,
  output logic        lsu2dcu_ready,
  input  logic        dcu2lsu_valid,
  input  logic        dcu2lsu_ready
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} lsu_fsm_e;

  lsu_fsm_e    state_reg;
  logic [2:0]  funct3_reg;
  logic [31:0] load_data;
  logic        illegal;
  logic        misalign;

  // Handshake outputs are pure state decodes so reset removes them at once.
  assign lsu2exu_ready = (state_reg == S_IDLE);
  assign lsu2dcu_valid = (state_reg == S_REQ);
  assign lsu2dcu_ready = (state_reg == S_WAIT);
  assign lsu2wbu_valid = (state_reg == S_RESP);

  // dcu_addr[1:0] doubles as the latched byte offset for lane extraction.
  ysyx_24080006_lsu_align u_align (
    .rdata        (dcu_rdata),
    .load_addr_lo (dcu_addr[1:0]),
    .load_funct3  (funct3_reg),
    .load_data    (load_data),
    .chk_mem_op   (exu_mem_op),
    .chk_funct3   (exu_funct3),
    .chk_addr_lo  (exu_addr[1:0]),
    .illegal      (illegal),
    .misalign     (misalign)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      funct3_reg  <= 3'd0;
      lsu_result  <= 32'd0;
      lsu_exc     <= EXC_NONE;
      lsu_badaddr <= 32'd0;
      dcu_addr    <= 32'd0;
      dcu_size    <= 2'd0;
      dcu_write   <= 1'b0;
      dcu_wdata   <= 32'd0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (exu2lsu_valid) begin
            funct3_reg  <= exu_funct3;
            lsu_result  <= 32'd0;
            lsu_exc     <= EXC_NONE;
            lsu_badaddr <= 32'd0;
            if (lsu_mem_op_e'(exu_mem_op) == MEM_NONE) begin
              lsu_result <= exu_result;
              state_reg  <= S_RESP;
            end else if (illegal) begin
              lsu_exc     <= EXC_ILLEGAL;
              lsu_badaddr <= exu_addr;
              state_reg   <= S_RESP;
            end else if (misalign) begin
              lsu_exc     <= (lsu_mem_op_e'(exu_mem_op) == MEM_STORE) ? EXC_ST_MISALIGN
                                                                      : EXC_LD_MISALIGN;
              lsu_badaddr <= exu_addr;
              state_reg   <= S_RESP;
            end else begin
              dcu_addr  <= exu_addr;
              dcu_size  <= exu_funct3[1:0];
              dcu_write <= (lsu_mem_op_e'(exu_mem_op) == MEM_STORE);
              dcu_wdata <= exu_wdata;
              state_reg <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (dcu2lsu_ready) state_reg <= S_WAIT;
        end
        S_WAIT: begin
          if (dcu2lsu_valid) begin
            lsu_result <= dcu_write ? 32'd0 : load_data;
            state_reg  <= S_RESP;
          end
        end
        S_RESP: begin
          if (wbu2lsu_ready) state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

`ifdef SIM_MODE
  always @(posedge clock) begin
    if (!reset)
      assert (!(dcu2lsu_valid && (state_reg != S_WAIT)))
        else $error("lsu: dcu2lsu_valid outside WAIT");
  end
`endif

endmodule
